seg_content_gen: RTL

Builds the 32-bit `seg_content` word that feeds `display_driver`. The word holds eight 4-bit digits, with digit 0 in [3:0]. On each `refresh` request the block samples a 32-bit `value` and produces the word in one of two forms. In hex mode the word passes `value` through unchanged. In decimal mode the block runs a sequential double-dabble conversion to packed BCD. `seg_content` changes only when a conversion completes, so the scanning display never shows a partly converted word.

---
 rtl/seg_content_gen.sv | 108 ++++++++++
 1 files changed

// File: rtl/seg_content_gen.sv
// seg_content_gen
// Builds the eight-digit word shown by display_driver. In hex mode the
// sampled value passes straight through. In decimal mode a 32-step
// double-dabble converts the value to packed BCD. seg_content is written
// only when a word is complete, so the scanning display never shows a
// half-converted word.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for refresh; hex requests are served here directly
// CONV  | one double-dabble iteration per clk edge, 32 in total
module seg_content_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        refresh,
    input  logic        sel_dec,
    input  logic [31:0] value,
    output logic [31:0] seg_content,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] bin_q,   bin_d;
    logic [31:0] bcd_q,   bcd_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [31:0] seg_q,   seg_d;
    logic        done_q,  done_d;

    logic [31:0] bcd_corr;
    logic [31:0] bcd_shift;

    // Add-3 correction on every nibble >= 5, then shift {bcd,bin} left by one.
    // Whatever leaves bcd[31] is dropped, which keeps the result mod 10^8.
    always_comb begin
        bcd_corr = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_corr[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_corr[30:0], bin_q[31]};
    end

    // Next-state logic for the request / conversion sequencer.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (refresh) begin
                    if (sel_dec) begin
                        bin_d   = value;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = CONV;
                    end else begin
                        seg_d  = value;
                        done_d = 1'b1;
                    end
                end
            end
            CONV: begin
                bcd_d = bcd_shift;
                bin_d = {bin_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    seg_d   = bcd_shift;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; a reset mid-conversion
    // abandons the word and suppresses done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            done_q  <= done_d;
        end
    end

    assign seg_content = seg_q;
    assign done        = done_q;
    assign busy        = (state_q == CONV);

endmodule
